// File: rtl/rs_scheduler.sv
// Reservation-station scheduler for one functional unit: tracks dependency masks,
// wakes entries on completion broadcasts and offers the lowest ready entry to the FU.
module rs_scheduler #(
  parameter  int RS_ENTRIES = 4,
  parameter  int NUM_FUS    = 4,
  parameter  int FU_ID      = 0,
  parameter  int PKT_W      = 64,
  localparam int SLOTS      = RS_ENTRIES * NUM_FUS,
  localparam int SLOT_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int IDX_W      = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_valid,
  input  logic [PKT_W-1:0]  disp_pkt,
  input  logic [SLOTS-1:0]  dependency_mask,
  output logic [IDX_W-1:0]  rs_entry_idx,
  output logic              rs_full,
  input  logic              cmpl_valid,
  input  logic [SLOT_W-1:0] cmpl_slot,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [PKT_W-1:0]  issue_pkt,
  output logic [SLOT_W-1:0] issue_slot,
  input  logic              flush
);

  localparam int BASE = FU_ID * RS_ENTRIES;

  typedef enum logic [1:0] {FREE, WAIT, READY, ISSUED} entry_state_e;

  entry_state_e           state_q [RS_ENTRIES];
  entry_state_e           state_d [RS_ENTRIES];
  logic [SLOTS-1:0]       mask_q  [RS_ENTRIES];
  logic [SLOTS-1:0]       mask_d  [RS_ENTRIES];
  logic [PKT_W-1:0]       pkt_q   [RS_ENTRIES];
  logic                   lock_q, lock_d;
  logic [IDX_W-1:0]       sel_q, sel_d;

  logic                   ready_any;
  logic [IDX_W-1:0]       ready_idx;
  logic [IDX_W-1:0]       sel_idx;
  logic                   alloc;
  logic                   accept;
  logic [SLOTS-1:0]       cmpl_bit;

  // Lowest FREE and lowest READY entries; descending loops leave the lowest match last.
  always_comb begin
    rs_full      = 1'b1;
    rs_entry_idx = '0;
    ready_any    = 1'b0;
    ready_idx    = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (state_q[i] == FREE) begin
        rs_full      = 1'b0;
        rs_entry_idx = IDX_W'(i);
      end
      if (state_q[i] == READY) begin
        ready_any = 1'b1;
        ready_idx = IDX_W'(i);
      end
    end
  end

  // A locked offer keeps its entry READY until accepted, so sel_q always names a valid packet.
  assign sel_idx     = lock_q ? sel_q : ready_idx;
  assign issue_valid = lock_q | ready_any;
  assign accept      = issue_valid & issue_ready;
  assign alloc       = disp_valid & ~rs_full;
  assign cmpl_bit    = cmpl_valid ? (SLOTS'(1) << cmpl_slot) : '0;
  assign issue_pkt   = issue_valid ? pkt_q[sel_idx] : '0;
  assign issue_slot  = SLOT_W'(BASE) + SLOT_W'(sel_idx);

  always_comb begin
    logic [SLOTS-1:0] new_mask;
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    state_d  = state_q;
    mask_d   = mask_q;
    lock_d   = 1'b0;
    sel_d    = sel_q;
    new_mask = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      unique case (state_q[i])
        FREE: begin
          if (alloc && rs_entry_idx == IDX_W'(i)) begin
            new_mask   = dependency_mask & ~(SLOTS'(1) << (BASE + i)) & ~cmpl_bit;
            mask_d[i]  = new_mask;
            state_d[i] = (new_mask != '0) ? WAIT : READY;
          end
        end
        WAIT: begin
          new_mask   = mask_q[i] & ~cmpl_bit;
          mask_d[i]  = new_mask;
          if (new_mask == '0) state_d[i] = READY;
        end
        READY: begin
          if (accept && sel_idx == IDX_W'(i)) state_d[i] = ISSUED;
        end
        ISSUED: begin
          if (cmpl_valid && cmpl_slot == SLOT_W'(BASE + i)) state_d[i] = FREE;
        end
        default: state_d[i] = FREE;
      endcase
    end
    if (issue_valid && !accept) begin
      lock_d = 1'b1;
      sel_d  = sel_idx;
    end
    if (flush) begin
      state_d = '{default: FREE};
      lock_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '{default: FREE};
      mask_q  <= '{default: '0};
      lock_q  <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      lock_q  <= lock_d;
      sel_q   <= sel_d;
    end
  end

  // NOTE: packet storage is deliberately not reset; it is only read from READY entries,
  // which were written on allocation, and issue_pkt is forced to zero otherwise.
  always_ff @(posedge clk) begin
    if (alloc) pkt_q[rs_entry_idx] <= disp_pkt;
  end

endmodule

// File: tb/tb_rs_scheduler.sv
// Self-checking bench for rs_scheduler (FU_ID=1): directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a behavioural model.
module tb_rs_scheduler;

  localparam int RS    = 4;
  localparam int NF    = 4;
  localparam int FU    = 1;
  localparam int PW    = 64;
  localparam int SLOTS = RS * NF;
  localparam int BASE  = FU * RS;

  logic              clk = 1'b0;
  logic              rst;
  logic              disp_valid;
  logic [PW-1:0]     disp_pkt;
  logic [SLOTS-1:0]  dependency_mask;
  logic [1:0]        rs_entry_idx;
  logic              rs_full;
  logic              cmpl_valid;
  logic [3:0]        cmpl_slot;
  logic              issue_valid;
  logic              issue_ready;
  logic [PW-1:0]     issue_pkt;
  logic [3:0]        issue_slot;
  logic              flush;

  int tests = 0;
  int fails = 0;

  rs_scheduler #(.RS_ENTRIES(RS), .NUM_FUS(NF), .FU_ID(FU), .PKT_W(PW)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_pkt(disp_pkt), .dependency_mask(dependency_mask),
    .rs_entry_idx(rs_entry_idx), .rs_full(rs_full),
    .cmpl_valid(cmpl_valid), .cmpl_slot(cmpl_slot),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_pkt(issue_pkt), .issue_slot(issue_slot), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 0=free 1=waiting 2=ready 3=issued; lock = offered entry or -1.
  int              m_st   [RS];
  logic [SLOTS-1:0] m_mask [RS];
  logic [PW-1:0]   m_pkt  [RS];
  int              m_lock = -1;
  bit              m_live = 0;

  function automatic int first_in(input int code);
    for (int e = 0; e < RS; e++) if (m_st[e] == code) return e;
    return -1;
  endfunction

  function automatic int offered();
    if (m_lock >= 0) return m_lock;
    return first_in(2);
  endfunction

  task automatic model_edge();
    int fidx, sel;
    bit acc;
    logic [SLOTS-1:0] cb;
    if (rst || flush) begin
      if (rst) m_live = 1;
      for (int e = 0; e < RS; e++) m_st[e] = 0;
      m_lock = -1;
      return;
    end
    if (!m_live) return;
    fidx = first_in(0);
    sel  = offered();
    acc  = (sel >= 0) && issue_ready;
    cb   = cmpl_valid ? (SLOTS'(1) << cmpl_slot) : '0;
    for (int e = 0; e < RS; e++) begin
      case (m_st[e])
        0: if (disp_valid && e == fidx) begin
             m_mask[e] = dependency_mask & ~(SLOTS'(1) << (BASE + e)) & ~cb;
             m_st[e]   = (m_mask[e] != 0) ? 1 : 2;
             m_pkt[e]  = disp_pkt;
           end
        1: begin
             m_mask[e] = m_mask[e] & ~cb;
             if (m_mask[e] == 0) m_st[e] = 2;
           end
        2: if (acc && sel == e) m_st[e] = 3;
        default: if (cmpl_valid && int'(cmpl_slot) == BASE + e) m_st[e] = 0;
      endcase
    end
    m_lock = (sel >= 0 && !acc) ? sel : -1;
  endtask

  // Compare process: update model at the edge, check DUT outputs 1 time unit later.
  always @(posedge clk) begin
    int fidx, sel;
    model_edge();
    #1;
    if (m_live) begin
      fidx = first_in(0);
      sel  = offered();
      check("model rs_full", PW'(rs_full), PW'(fidx < 0));
      check("model rs_entry_idx", PW'(rs_entry_idx), PW'((fidx < 0) ? 0 : fidx));
      check("model issue_valid", PW'(issue_valid), PW'(sel >= 0));
      check("model issue_slot", PW'(issue_slot), PW'(BASE + ((sel < 0) ? 0 : sel)));
      check("model issue_pkt", issue_pkt, (sel < 0) ? '0 : m_pkt[sel]);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    rst = 0; flush = 0; disp_valid = 0; cmpl_valid = 0; issue_ready = 0;
  endtask

  logic [PW-1:0] pk [4];

  initial begin
    rst = 1; flush = 0; disp_valid = 0; disp_pkt = '0; dependency_mask = '0;
    cmpl_valid = 0; cmpl_slot = '0; issue_ready = 0;
    step(); step();
    idle();
    check("reset rs_full", PW'(rs_full), 0);
    check("reset rs_entry_idx", PW'(rs_entry_idx), 0);
    check("reset issue_valid", PW'(issue_valid), 0);
    check("reset issue_pkt", issue_pkt, 0);
    check("reset issue_slot", PW'(issue_slot), 4);

    // Single dispatch, issue, completion frees it.
    disp_valid = 1; disp_pkt = 64'hA5A5_0000_1111_2222; dependency_mask = '0;
    check("d1 rs_entry_idx", PW'(rs_entry_idx), 0);
    step(); idle();
    check("d1 issue_valid", PW'(issue_valid), 1);
    check("d1 issue_slot", PW'(issue_slot), 4);
    check("d1 issue_pkt", issue_pkt, 64'hA5A5_0000_1111_2222);
    issue_ready = 1; step(); idle();
    check("d1 issued valid", PW'(issue_valid), 0);
    check("d1 issued idx", PW'(rs_entry_idx), 1);
    cmpl_valid = 1; cmpl_slot = 4; step(); idle();
    check("d1 freed idx", PW'(rs_entry_idx), 0);

    // Fill with entries waiting on slot 9, overflow ignored, then wake and drain in order.
    for (int k = 0; k < 4; k++) begin
      pk[k] = 64'h1000 + 64'(k);
      disp_valid = 1; disp_pkt = pk[k]; dependency_mask = 16'h0200;
      step();
    end
    idle();
    check("fill rs_full", PW'(rs_full), 1);
    check("fill issue_valid", PW'(issue_valid), 0);
    disp_valid = 1; disp_pkt = 64'hDEAD; dependency_mask = '0;
    step(); idle();
    check("overflow rs_full", PW'(rs_full), 1);
    check("overflow issue_valid", PW'(issue_valid), 0);
    cmpl_valid = 1; cmpl_slot = 9; step(); idle();
    issue_ready = 1;
    for (int k = 0; k < 4; k++) begin
      check("drain issue_slot", PW'(issue_slot), PW'(4 + k));
      check("drain issue_pkt", issue_pkt, pk[k]);
      step();
    end
    idle();
    check("drain done valid", PW'(issue_valid), 0);
    for (int k = 0; k < 4; k++) begin
      cmpl_valid = 1; cmpl_slot = 4'(4 + k); step();
    end
    idle();
    check("drain freed full", PW'(rs_full), 0);

    // Same-cycle wakeup bypass.
    disp_valid = 1; disp_pkt = 64'hB0B0; dependency_mask = 16'h0080;
    cmpl_valid = 1; cmpl_slot = 7;
    step(); idle();
    check("bypass issue_valid", PW'(issue_valid), 1);
    check("bypass issue_slot", PW'(issue_slot), 4);
    issue_ready = 1; step(); idle();
    cmpl_valid = 1; cmpl_slot = 4; step(); idle();

    // Locked offer of entry 2 survives entry 0 becoming ready.
    disp_valid = 1; dependency_mask = 16'h1000; disp_pkt = 64'hE0; step();
    disp_pkt = 64'hE1; step();
    dependency_mask = 16'h0000; disp_pkt = 64'hE2; step();
    idle();
    check("lock initial slot", PW'(issue_slot), 6);
    cmpl_valid = 1; cmpl_slot = 12; step(); idle();
    for (int k = 0; k < 3; k++) begin
      check("lock held slot", PW'(issue_slot), 6);
      check("lock held pkt", issue_pkt, 64'hE2);
      step();
    end
    issue_ready = 1; step(); idle();
    check("lock next slot", PW'(issue_slot), 4);
    check("lock next pkt", issue_pkt, 64'hE0);

    // Flush with dispatch while three entries are busy.
    flush = 1; disp_valid = 1; disp_pkt = 64'hF1; dependency_mask = '0;
    step(); idle();
    check("flush rs_full", PW'(rs_full), 0);
    check("flush issue_valid", PW'(issue_valid), 0);
    check("flush rs_entry_idx", PW'(rs_entry_idx), 0);
    step();
    check("flush no packet", PW'(issue_valid), 0);

    // Reset in the middle of an offer.
    disp_valid = 1; disp_pkt = 64'hC1; step(); idle();
    rst = 1; disp_valid = 1; disp_pkt = 64'hC2; issue_ready = 1; cmpl_valid = 1; cmpl_slot = 4;
    step(); idle();
    check("rst mid rs_full", PW'(rs_full), 0);
    check("rst mid issue_valid", PW'(issue_valid), 0);
    check("rst mid issue_slot", PW'(issue_slot), 4);
    check("rst mid issue_pkt", issue_pkt, 0);

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 4000; n++) begin
      rst             = ($urandom_range(0, 199) == 0);
      flush           = ($urandom_range(0, 59) == 0);
      disp_valid      = ($urandom_range(0, 1) == 1);
      disp_pkt        = {$urandom, $urandom};
      dependency_mask = 16'($urandom & $urandom & $urandom);
      cmpl_valid      = ($urandom_range(0, 9) < 6);
      cmpl_slot       = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15))
                                                    : 4'(BASE + $urandom_range(0, RS - 1));
      issue_ready     = ($urandom_range(0, 1) == 1);
      step();
    end
    idle();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
